// File: rtl/motor_step_gen_pkg.sv
// Shared types and defaults for the motor step/direction generator.
package MCPkg;

  typedef enum logic [1:0] {
    OK    = 2'd0,
    LIMIT = 2'd1,
    PFAIL = 2'd2,
    ABORT = 2'd3
  } step_status_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_END   = 3'd4
  } step_state_t;

  localparam int unsigned DIR_SETUP_CYC_DEF = 40;

  // States in which the driver is actively moving and stop conditions apply.
  function automatic logic is_running(input step_state_t st);
    return (st == ST_SETUP) || (st == ST_HIGH) || (st == ST_LOW);
  endfunction

endpackage

// File: rtl/motor_step_gen_if.sv
// Move command / completion handshake between the command layer and one motor channel.
interface motor_step_gen_if
  import MCPkg::*;
#(
  parameter int unsigned STEP_W = 16,
  parameter int unsigned HP_W   = 16
) ();

  logic              start_i;
  logic              ready_o;
  logic [STEP_W-1:0] steps_i;
  logic              dir_i;
  logic [HP_W-1:0]   half_period_i;
  logic              abort_i;
  logic              done_o;
  step_status_t      status_o;
  logic [STEP_W-1:0] remaining_o;

  modport master (
    output start_i, steps_i, dir_i, half_period_i, abort_i,
    input  ready_o, done_o, status_o, remaining_o
  );

  modport slave (
    input  start_i, steps_i, dir_i, half_period_i, abort_i,
    output ready_o, done_o, status_o, remaining_o
  );

endinterface

// File: rtl/motor_step_gen_sync.sv
// Parametrised-width 2-FF synchroniser, asynchronous active-low reset to 0.
module bit_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk_ik,
  input  logic         rst_n_ir,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;

  always_ff @(posedge clk_ik or negedge rst_n_ir) begin
    if (!rst_n_ir) begin
      meta_q <= '0;
      q_o    <= '0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/motor_step_gen.sv
// Step/direction pulse generator for one stepper channel with limit/pfail/abort stop.
// Optional build macro MOTOR_BOOST_EN: drive pl_boost_o while a move is running.
module motor_step_gen
  import MCPkg::*;
#(
  parameter int unsigned DIR_SETUP_CYC = DIR_SETUP_CYC_DEF,
  parameter int unsigned STEP_W        = 16,
  parameter int unsigned HP_W          = 16
) (
  input  logic             clk_ik,
  input  logic             rst_n_ir,
  input  logic             enable_i,
  motor_step_gen_if.slave  cmd,
  output logic             pl_clk_o,
  output logic             pl_dir_o,
  output logic             pl_en_o,
  output logic             pl_boost_o,
  input  logic             pl_pfail_i,
  input  logic             pl_sw_outa_i,
  input  logic             pl_sw_outb_i
);

  localparam int unsigned CNT_W = (HP_W > 8) ? HP_W : 8;

  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [HP_W-1:0]   HP_ONE     = HP_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
  localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(DIR_SETUP_CYC - 1);

  logic [2:0] sync_q;
  logic       pfail_s;
  logic       sw_a_s;
  logic       sw_b_s;

  bit_sync #(.W(3)) u_sync (
    .clk_ik   (clk_ik),
    .rst_n_ir (rst_n_ir),
    .d_i      ({pl_pfail_i, pl_sw_outa_i, pl_sw_outb_i}),
    .q_o      (sync_q)
  );

  assign pfail_s = sync_q[2];
  assign sw_a_s  = sync_q[1];
  assign sw_b_s  = sync_q[0];

  step_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic              dir_q, dir_d;
  step_status_t      status_q, status_d;
  logic              clk_q;
  logic              en_q;

  logic              stop_req;
  step_status_t      stop_code;
  logic [CNT_W-1:0]  phase_last;

  // Stop priority: power fail, then abort/disable, then the switch we are heading into.
  always_comb begin
    stop_req  = 1'b0;
    stop_code = OK;
    if (pfail_s) begin
      stop_req  = 1'b1;
      stop_code = PFAIL;
    end else if (cmd.abort_i || !enable_i) begin
      stop_req  = 1'b1;
      stop_code = ABORT;
    end else if ((sw_a_s && dir_q) || (sw_b_s && !dir_q)) begin
      stop_req  = 1'b1;
      stop_code = LIMIT;
    end
  end

  assign phase_last = CNT_W'(hp_q - HP_ONE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    hp_d     = hp_q;
    dir_d    = dir_q;
    status_d = status_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd.start_i) begin
          rem_d = cmd.steps_i;
          hp_d  = (cmd.half_period_i == '0) ? HP_ONE : cmd.half_period_i;
          if (cmd.steps_i == '0) begin
            state_d  = ST_END;
            status_d = OK;
          end else if (!enable_i) begin
            state_d  = ST_END;
            status_d = ABORT;
          end else begin
            state_d  = ST_SETUP;
            dir_d    = cmd.dir_i;
            status_d = OK;
            cnt_d    = SETUP_LAST;
          end
        end
      end

      ST_SETUP: begin
        if (stop_req) begin
          state_d  = ST_END;
          status_d = stop_code;
        end else if (cnt_q == '0) begin
          state_d = ST_HIGH;
          cnt_d   = phase_last;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_HIGH: begin
        if (stop_req) begin
          state_d  = ST_END;
          status_d = stop_code;
        end else if (cnt_q == '0) begin
          state_d = ST_LOW;
          cnt_d   = phase_last;
          rem_d   = rem_q - STEP_ONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_LOW: begin
        if (stop_req) begin
          state_d  = ST_END;
          status_d = stop_code;
        end else if (cnt_q == '0) begin
          if (rem_q != '0) begin
            state_d = ST_HIGH;
            cnt_d   = phase_last;
          end else begin
            state_d  = ST_END;
            status_d = OK;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_END: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_ik or negedge rst_n_ir) begin
    if (!rst_n_ir) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      hp_q     <= '0;
      dir_q    <= 1'b0;
      status_q <= OK;
      clk_q    <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      hp_q     <= hp_d;
      dir_q    <= dir_d;
      status_q <= status_d;
      clk_q    <= (state_d == ST_HIGH);
      en_q     <= enable_i;
    end
  end

`ifdef MOTOR_BOOST_EN
  logic boost_q;

  // Covers the running states plus the single END cycle that follows a run.
  always_ff @(posedge clk_ik or negedge rst_n_ir) begin
    if (!rst_n_ir) begin
      boost_q <= 1'b0;
    end else begin
      boost_q <= is_running(state_d) || is_running(state_q);
    end
  end

  assign pl_boost_o = boost_q;
`else
  assign pl_boost_o = 1'b0;
`endif

  assign cmd.ready_o     = (state_q == ST_IDLE);
  assign cmd.done_o      = (state_q == ST_END);
  assign cmd.status_o    = status_q;
  assign cmd.remaining_o = rem_q;

  assign pl_clk_o = clk_q;
  assign pl_dir_o = dir_q;
  assign pl_en_o  = en_q;

endmodule

// File: tb/tb_motor_step_gen.sv
// Self-checking bench for motor_step_gen: directed moves plus randomized moves vs. a timing model.
module tb_motor_step_gen;
  import MCPkg::*;

  localparam int unsigned D = 40;

  logic clk_ik = 1'b0;
  logic rst_n_ir;
  logic enable_i;
  logic pl_clk_o, pl_dir_o, pl_en_o, pl_boost_o;
  logic pl_pfail_i, pl_sw_outa_i, pl_sw_outb_i;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic        last_dir = 1'b0;

  motor_step_gen_if #(.STEP_W(16), .HP_W(16)) cmd ();

  motor_step_gen #(.DIR_SETUP_CYC(D), .STEP_W(16), .HP_W(16)) dut (
    .clk_ik       (clk_ik),
    .rst_n_ir     (rst_n_ir),
    .enable_i     (enable_i),
    .cmd          (cmd),
    .pl_clk_o     (pl_clk_o),
    .pl_dir_o     (pl_dir_o),
    .pl_en_o      (pl_en_o),
    .pl_boost_o   (pl_boost_o),
    .pl_pfail_i   (pl_pfail_i),
    .pl_sw_outa_i (pl_sw_outa_i),
    .pl_sw_outb_i (pl_sw_outb_i)
  );

  always #5 clk_ik = ~clk_ik;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 none, 1 abort_i, 2 sw_outa, 3 sw_outb, 4 pfail,
  //       5 pfail at a + abort at a+2 (both reach the FSM together), 6 enable drop.
  // Cycle t is the cycle following the accept edge shifted by t-1.
  task automatic run_move(input int unsigned steps, input int unsigned hp, input logic dir,
                          input logic en, input int unsigned kind, input int unsigned a);
    int unsigned  hpe, end_nat, end_eff, completed, done_cnt;
    logic         direct, match, exp_dir, exp_clk, exp_boost;
    step_status_t st;

    hpe     = (hp == 0) ? 1 : hp;
    direct  = (steps == 0) || !en;
    end_nat = direct ? 1 : 1 + D + 2 * hpe * steps;
    end_eff = end_nat;
    st      = (steps != 0 && !en) ? ABORT : OK;
    match   = (kind == 2 && dir) || (kind == 3 && !dir);
    if (!direct) begin
      if ((kind == 1 || kind == 6) && a >= 1 && a + 1 <= end_nat) begin
        end_eff = a + 1;
        st      = ABORT;
      end else if ((kind == 4 || kind == 5) && a >= 1 && a + 3 <= end_nat) begin
        end_eff = a + 3;
        st      = PFAIL;
      end else if (match && a >= 1 && a + 3 <= end_nat) begin
        end_eff = a + 3;
        st      = LIMIT;
      end
    end
    completed = 0;
    if (!direct)
      for (int unsigned k = 0; k < steps; k++)
        if (1 + D + 2 * hpe * k + hpe < end_eff) completed++;
    exp_dir  = direct ? last_dir : dir;
    done_cnt = 0;

    @(posedge clk_ik); #1;
    chk("ready_before_accept", cmd.ready_o, 1'b1);
    cmd.start_i       = 1'b1;
    cmd.steps_i       = 16'(steps);
    cmd.half_period_i = 16'(hp);
    cmd.dir_i         = dir;
    enable_i          = en;
    @(posedge clk_ik); #1;
    cmd.start_i = 1'b0;

    for (int unsigned t = 1; t <= end_eff + 1; t++) begin
      if (t == a) begin
        case (kind)
          1: cmd.abort_i = 1'b1;
          2: pl_sw_outa_i = 1'b1;
          3: pl_sw_outb_i = 1'b1;
          4, 5: pl_pfail_i = 1'b1;
          6: enable_i = 1'b0;
          default: ;
        endcase
      end
      if (kind == 5 && t == a + 2) cmd.abort_i = 1'b1;
      // A start pulse while busy must be ignored.
      if (!direct && end_eff > 4 && t == 3) begin
        cmd.start_i = 1'b1;
        cmd.steps_i = 16'd7;
        cmd.dir_i   = ~dir;
      end
      if (t == 4) cmd.start_i = 1'b0;

      @(negedge clk_ik);
      exp_clk = (!direct && t >= 1 + D && t < end_eff) ? (((t - 1 - D) % (2 * hpe)) < hpe) : 1'b0;
`ifdef MOTOR_BOOST_EN
      exp_boost = !direct && t <= end_eff;
`else
      exp_boost = 1'b0;
`endif
      if (cmd.done_o === 1'b1) done_cnt++;
      chk("pl_clk", pl_clk_o, exp_clk);
      chk("pl_dir", pl_dir_o, exp_dir);
      chk("pl_boost", pl_boost_o, exp_boost);
      chk("ready", cmd.ready_o, t > end_eff);
      chk("done", cmd.done_o, t == end_eff);
      if (t == 1) chk("pl_en", pl_en_o, en);
      if (t >= end_eff) begin
        chk("status", cmd.status_o, st);
        chk("remaining", cmd.remaining_o, steps - completed);
      end
      @(posedge clk_ik); #1;
    end
    chk("done_once", done_cnt, 1);

    cmd.abort_i  = 1'b0;
    pl_pfail_i   = 1'b0;
    pl_sw_outa_i = 1'b0;
    pl_sw_outb_i = 1'b0;
    enable_i     = 1'b1;
    last_dir     = exp_dir;
    repeat (4) @(posedge clk_ik);
  endtask

  initial begin
    int unsigned r_steps, r_hp, r_kind, r_end, r_a, hpe_r, done_cnt;
    logic        r_dir;

    rst_n_ir          = 1'b0;
    enable_i          = 1'b1;
    cmd.start_i       = 1'b0;
    cmd.steps_i       = '0;
    cmd.dir_i         = 1'b0;
    cmd.half_period_i = '0;
    cmd.abort_i       = 1'b0;
    pl_pfail_i        = 1'b0;
    pl_sw_outa_i      = 1'b0;
    pl_sw_outb_i      = 1'b0;

    repeat (3) @(posedge clk_ik);
    @(negedge clk_ik);
    chk("rst_ready", cmd.ready_o, 1'b1);
    chk("rst_done", cmd.done_o, 1'b0);
    chk("rst_status", cmd.status_o, OK);
    chk("rst_remaining", cmd.remaining_o, 0);
    chk("rst_pl_clk", pl_clk_o, 1'b0);
    chk("rst_pl_dir", pl_dir_o, 1'b0);
    chk("rst_pl_en", pl_en_o, 1'b0);
    chk("rst_pl_boost", pl_boost_o, 1'b0);
    rst_n_ir = 1'b1;
    repeat (3) @(posedge clk_ik);

    run_move(4, 3, 1'b1, 1'b1, 0, 0);       // nominal: done at N+65
    run_move(0, 5, 1'b0, 1'b1, 0, 0);       // zero steps, pl_dir stays 1
    run_move(3, 2, 1'b0, 1'b0, 0, 0);       // disabled accept -> ABORT
    run_move(100, 2, 1'b1, 1'b1, 2, 79);    // switch A after 10 pulses -> LIMIT, 90 left
    run_move(100, 2, 1'b1, 1'b1, 3, 79);    // opposite switch ignored
    run_move(10, 2, 1'b0, 1'b1, 5, 50);     // pfail and abort together -> PFAIL
    run_move(3, 0, 1'b1, 1'b1, 0, 0);       // hp=0 behaves as hp=1
    run_move(5, 1, 1'b0, 1'b1, 1, 20);      // abort during SETUP
    run_move(6, 3, 1'b1, 1'b1, 6, 50);      // enable dropped mid-move

    // Asynchronous reset while the step pulse is high.
    @(posedge clk_ik); #1;
    cmd.start_i       = 1'b1;
    cmd.steps_i       = 16'd5;
    cmd.half_period_i = 16'd4;
    cmd.dir_i         = 1'b1;
    @(posedge clk_ik); #1;
    cmd.start_i = 1'b0;
    repeat (D + 1) @(posedge clk_ik);
    @(negedge clk_ik);
    chk("mid_high_pl_clk", pl_clk_o, 1'b1);
    #1 rst_n_ir = 1'b0;
    #1;
    chk("async_rst_pl_clk", pl_clk_o, 1'b0);
    chk("async_rst_pl_boost", pl_boost_o, 1'b0);
    chk("async_rst_ready", cmd.ready_o, 1'b1);
    chk("async_rst_done", cmd.done_o, 1'b0);
    chk("async_rst_pl_dir", pl_dir_o, 1'b0);
    chk("async_rst_remaining", cmd.remaining_o, 0);
    chk("async_rst_status", cmd.status_o, OK);
    repeat (2) @(posedge clk_ik);
    @(negedge clk_ik);
    rst_n_ir = 1'b1;
    done_cnt = 0;
    repeat (8) begin
      @(negedge clk_ik);
      if (cmd.done_o !== 1'b0) done_cnt++;
    end
    chk("async_rst_no_done", done_cnt, 0);
    last_dir = 1'b0;

    for (int i = 0; i < 15; i++) begin
      r_steps = $urandom_range(1, 6);
      r_hp    = $urandom_range(0, 3);
      r_dir   = 1'($urandom_range(0, 1));
      r_kind  = $urandom_range(0, 6);
      hpe_r   = (r_hp == 0) ? 1 : r_hp;
      r_end   = 1 + D + 2 * hpe_r * r_steps;
      r_a     = $urandom_range(1, r_end + 1);
      run_move(r_steps, r_hp, r_dir, 1'b1, r_kind, r_a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/motor_step_gen.md
# motor_step_gen

Per-motor step/direction pulse generator that drives one channel of the motor board's stepper driver pins (pl_clk, pl_dir, pl_en, pl_boost) and watches that channel's pl_pfail and limit-switch returns (pl_sw_outa, pl_sw_outb). It sits directly upstream of the motor pin bundle: the top level instantiates 16 copies, one per motor index 1..16, on the 40 MHz domain. Each copy accepts move commands from the register/command layer through a valid/ready handshake, reports a completion status, and stops early on limit hit, power fail or abort.

## Interface
- DIR_SETUP_CYC, 40: cycles between the pl_dir update and the first pl_clk rising edge (1 µs at 40 MHz); legal range 1..255.
- STEP_W, 16: width of the step count.
- HP_W, 16: width of the half-period divider.
- clk_ik  in  1  40 MHz system clock (ClkRs40MHz_ix.clk at the top level).
- rst_n_ir  in  1  asynchronous, active-low reset.
- enable_i  in  1  motor enable from the register bank; drives pl_en.
- start_i  in  1  move request valid.
- ready_o  out  1  block idle; a move is accepted when start_i && ready_o.
- steps_i  in  STEP_W  number of steps to issue.
- dir_i  in  1  direction, 1 = towards switch A.
- half_period_i  in  HP_W  pl_clk high time and low time, in cycles.
- abort_i  in  1  stop the current move.
- done_o  out  1  one-cycle pulse at move end.
- status_o  out  2  step_status_t; valid while done_o is high and held afterwards.
- remaining_o  out  STEP_W  steps not yet issued.
- pl_clk_o, pl_dir_o, pl_en_o, pl_boost_o  out  1 each  driver pins.
- pl_pfail_i, pl_sw_outa_i, pl_sw_outb_i  in  1 each  asynchronous driver and switch returns, active-high.

## Operation
- The three asynchronous inputs pass through 2-FF synchronisers before use.
- FSM states are IDLE, SETUP, HIGH, LOW and END.
- IDLE: ready_o=1. On accept, latch steps, dir and half-period; a half-period of 0 is treated as 1. Go to SETUP and set pl_dir_o to dir_i.
  - Exception: if steps_i=0, or enable_i=0, go straight to END. Status is OK for steps_i=0 and ABORT for enable_i=0. pl_dir_o is not changed.
- SETUP: count DIR_SETUP_CYC cycles, then go to HIGH.
- HIGH: pl_clk_o=1 for half_period cycles, then go to LOW and decrement remaining_o.
- LOW: pl_clk_o=0 for half_period cycles. Go to HIGH if remaining_o>0, else go to END with status OK.
- Stop conditions are checked every cycle in SETUP, HIGH and LOW, in this priority order:
  1. synced pfail → PFAIL.
  2. abort_i or enable_i=0 → ABORT.
  3. synced sw_outa with dir=1, or synced sw_outb with dir=0 → LIMIT.
  - On a stop, go to END next cycle and force pl_clk_o low. A truncated high pulse does not decrement remaining_o.
- A limit switch opposite to the current direction is ignored, so the motor can always back off a switch.
- END: done_o=1 for one cycle, then return to IDLE.
- status_o and remaining_o hold their value until the next accept.
- pl_en_o is a registered copy of enable_i in every state.

## Timing
- Reset values: ready_o=1, done_o=0, status_o=OK, remaining_o=0, pl_clk_o=0, pl_dir_o=0, pl_en_o=0, pl_boost_o=0, FSM in IDLE.
- Accept at edge N: ready_o=0 and pl_dir_o valid from N+1. The first pl_clk_o rise is at N+1+DIR_SETUP_CYC.
- Step period is 2·half_period cycles, with no dead cycles between steps.
- After the last LOW phase: done_o high for exactly one cycle, then ready_o=1 on the following cycle.
- Limit and pfail response: at most 2 cycles of synchroniser delay plus 1 cycle to END. abort_i: 1 cycle to END.
- start_i is ignored while ready_o=0; there is no queueing.
- Reset asserted mid-move: all outputs return to their reset values immediately (asynchronous). No done_o is issued.

## Configuration
- MOTOR_BOOST_EN defined: pl_boost_o=1 in SETUP, HIGH and LOW, plus 1 cycle into END; 0 otherwise.
- MOTOR_BOOST_EN undefined: pl_boost_o is tied to 0 and no boost logic is generated.

## Structure
- MCPkg holds:
  - step_status_t: 2-bit enum, OK=0, LIMIT=1, PFAIL=2, ABORT=3.
  - the default DIR_SETUP_CYC.
- Sub-module bit_sync: parametrised-width 2-FF synchroniser with asynchronous active-low reset to 0. One instance, width 3, covers pfail, sw_outa and sw_outb.

## Test plan
- steps=4, hp=3, dir=1, DIR_SETUP_CYC=40 → pl_dir rises at N+1; first pl_clk rise at N+41; 4 pulses, each 3 high / 3 low; done_o at N+65 with status OK and remaining 0.
- steps=0 → done_o at N+1 with status OK; no pl_clk edges; pl_dir unchanged.
- steps=100, hp=2, dir=1, pl_sw_outa asserted after 10 pulses → pl_clk low within 3 cycles; status LIMIT; remaining 90.
- Same move with pl_sw_outb asserted (opposite switch) → ignored; all 100 steps complete with status OK.
- pfail and abort_i asserted in the same cycle → status PFAIL; done_o exactly once.
- rst_n_ir pulsed low during HIGH → pl_clk_o and pl_boost_o go to 0 without waiting for a clock edge; ready_o=1; no done_o.
- hp=0 → behaves exactly as hp=1.
